exception_vector_unit: RTL
==========================

// Module: exception_vector_unit
// PURPOSE
//  Upstream stage of the PC-source selector. Accepts exception pulses from control/ALU,
//  saves the faulting PC into EPC, and fetches the handler address byte from memory
//  (vector at VEC_BASE+cause). Drives exception_destiny (mux input 00) and epc_out (mux
//  input 01), and pulses pc_load so control writes the PC with PC-source selector 00.
// PARAMETERS
//  VEC_BASE     253  byte address of first vector (253 opcode, 254 overflow, 255 div0)
//  MEM_LATENCY  1    cycles from mem_rd_req until mem_data_in is valid (1..7)
//  PC_OFFSET    4    subtracted from pc_current when EPC is captured
// PORTS
//  clk                in   1   clock, all state on rising edge
//  reset              in   1   synchronous, active-low reset
//  exc_opcode         in   1   invalid-opcode pulse (1 cycle)
//  exc_overflow       in   1   ALU overflow pulse
//  exc_div0           in   1   divide-by-zero pulse
//  pc_current         in   32  current PC (already incremented by fetch)
//  mem_data_in        in   32  memory read data; bits [7:0] = byte at mem_addr
//  mem_rd_req         out  1   memory read strobe, high during FETCH only
//  mem_addr           out  32  vector address, valid while mem_rd_req high
//  exception_destiny  out  32  handler address, zero-extended vector byte
//  epc_out            out  32  saved return address
//  pc_load            out  1   1-cycle pulse: write PC from exception_destiny
//  busy               out  1   high in any state except IDLE
// BEHAVIOUR
//  - Reset (reset==0 at edge): state IDLE; all outputs 0; wait counter 0. Applies mid-
//    sequence: mem_rd_req/pc_load drop at that edge, pending fetch abandoned.
//  - States: IDLE -> FETCH -> WAIT -> LOAD -> IDLE.
//  - IDLE: on any exc_* high, latch cause, epc_out <= pc_current - PC_OFFSET (mod 2^32),
//    go FETCH. Simultaneous causes: priority opcode > overflow > div0; others dropped.
//  - FETCH (1 cycle): mem_rd_req=1, mem_addr = VEC_BASE + idx (idx 0/1/2); counter loads
//    MEM_LATENCY-1; next WAIT (skipped to LOAD if MEM_LATENCY==1).
//  - WAIT: counter decrements; at 0 go LOAD.
//  - LOAD (1 cycle): exception_destiny <= {24'b0, mem_data_in[7:0]}; pc_load=1 the same
//    cycle the register updates is NOT allowed -- pc_load asserts in the cycle AFTER
//    capture (LOAD registers, then IDLE-entry cycle pulses pc_load). Total: exception
//    pulse at cycle 0 -> pc_load high at cycle MEM_LATENCY+2.
//  - exc_* pulses while busy are ignored (no re-entry, EPC not overwritten).
//  - exception_destiny and epc_out hold until next accepted exception or reset.
//  - pc_current=0: epc_out wraps to 32'hFFFF_FFFC, no special handling.
// CONFIGURATION
//  EXC_CAUSE_REG_EN defined: extra port cause_out out 2 = registered cause code
//   (01 opcode, 10 overflow, 11 div0), written with EPC, reset 00, held otherwise.
//  Not defined: no cause_out port, no cause register; all other behaviour identical.
// STRUCTURE
//  Package exc_pkg: state enum (IDLE, FETCH, WAIT, LOAD), cause codes (2-bit), vector
//   index constants, default VEC_BASE.
//  One sub-module: exc_wait_counter (3-bit down-counter, load/dec/zero flag) for WAIT.
// TESTING
//  - exc_overflow at PC=0x40, byte[254]=0x80 -> mem_addr=254, epc_out=0x3C,
//    exception_destiny=0x80, one-cycle pc_load at cycle 3 (MEM_LATENCY=1).
//  - exc_opcode+exc_div0 same cycle -> mem_addr=253 only; div0 dropped; cause_out=01 (EN).
//  - exc_div0 during busy -> ignored; epc_out unchanged; single pc_load.
//  - reset=0 asserted in WAIT (MEM_LATENCY=4) -> next edge all outputs 0, state IDLE,
//    no pc_load.
//  - MEM_LATENCY=3, byte=0xFF at 255 -> pc_load at cycle 5, exception_destiny=0xFF.
//  - pc_current=0 with exc_opcode -> epc_out=0xFFFF_FFFC.

Source files
------------

// File: rtl/exc_pkg.sv
// Package exc_pkg: shared types and constants for the exception vector unit.
//   state_t         - sequencer states IDLE -> FETCH -> WAIT -> LOAD
//   cause_t         - 2-bit cause codes (00 none, 01 opcode, 10 overflow, 11 div0)
//   VEC_IDX_*       - offset of each cause's vector byte from VEC_BASE
//   DEFAULT_VEC_BASE- byte address of the first vector
//   prioritise()    - resolves simultaneous exception pulses to one cause
//   cause_to_idx()  - maps a cause code to its vector index
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        LOAD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_OPCODE   = 2'b01,
        CAUSE_OVERFLOW = 2'b10,
        CAUSE_DIV0     = 2'b11
    } cause_t;

    localparam logic [1:0] VEC_IDX_OPCODE   = 2'd0;
    localparam logic [1:0] VEC_IDX_OVERFLOW = 2'd1;
    localparam logic [1:0] VEC_IDX_DIV0     = 2'd2;

    localparam int unsigned DEFAULT_VEC_BASE = 253;

    // Opcode beats overflow beats div0; the losers are simply dropped.
    function automatic cause_t prioritise(input logic opcode,
                                          input logic overflow,
                                          input logic div0);
        if (opcode)        return CAUSE_OPCODE;
        else if (overflow) return CAUSE_OVERFLOW;
        else if (div0)     return CAUSE_DIV0;
        else               return CAUSE_NONE;
    endfunction

    function automatic logic [1:0] cause_to_idx(input cause_t cause);
        case (cause)
            CAUSE_OVERFLOW: return VEC_IDX_OVERFLOW;
            CAUSE_DIV0:     return VEC_IDX_DIV0;
            default:        return VEC_IDX_OPCODE;
        endcase
    endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// exc_wait_counter: 3-bit down-counter that times the memory read latency.
//   clk        in  clock
//   reset      in  synchronous active-low reset (count -> 0)
//   load       in  load load_value this cycle (has priority over dec)
//   load_value in  3-bit value to load
//   dec        in  decrement this cycle (saturates at 0)
//   zero       out the count after this cycle's load/dec is zero
module exc_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] count_q;
    logic [2:0] count_next;

    always_comb begin
        count_next = count_q;
        if (load)
            count_next = load_value;
        else if (dec && count_q != 3'd0)
            count_next = count_q - 3'd1;
    end

    // Flag looks at the next value so the sequencer can leave WAIT on the
    // same edge the count reaches zero, and skip WAIT when loading zero.
    assign zero = (count_next == 3'd0);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset)
            count_q <= 3'd0;
        else
            count_q <= count_next;
    end

endmodule

// File: rtl/exception_vector_unit.sv
// exception_vector_unit: accepts exception pulses, saves the return address in
// EPC, fetches the handler byte from VEC_BASE+index and pulses pc_load.
//   clk               in   clock
//   reset             in   synchronous active-low reset
//   exc_opcode        in   invalid-opcode pulse
//   exc_overflow      in   ALU overflow pulse
//   exc_div0          in   divide-by-zero pulse
//   pc_current        in   32-bit PC (already incremented)
//   mem_data_in       in   32-bit memory read data, byte in [7:0]
//   mem_rd_req        out  memory read strobe, high in FETCH
//   mem_addr          out  vector byte address
//   exception_destiny out  handler address (zero-extended vector byte)
//   epc_out           out  saved return address
//   pc_load           out  one-cycle pulse after exception_destiny updates
//   cause_out         out  registered cause code (only with EXC_CAUSE_REG_EN)
//   busy              out  high whenever the sequencer is not IDLE
// Optional feature macro: EXC_CAUSE_REG_EN adds the cause_out register/port.
module exception_vector_unit
    import exc_pkg::*;
#(
    parameter int unsigned VEC_BASE    = DEFAULT_VEC_BASE,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned PC_OFFSET   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_current,
    input  logic [31:0] mem_data_in,
    output logic        mem_rd_req,
    output logic [31:0] mem_addr,
    output logic [31:0] exception_destiny,
    output logic [31:0] epc_out,
    output logic        pc_load,
`ifdef EXC_CAUSE_REG_EN
    output logic [1:0]  cause_out,
`endif
    output logic        busy
);

    state_t     state;
    cause_t     cause_sel;
    logic       exc_any;
    logic       cnt_zero;
    logic       unused_mem_bits;

    assign cause_sel = prioritise(exc_opcode, exc_overflow, exc_div0);
    assign exc_any   = exc_opcode | exc_overflow | exc_div0;

    // Only the addressed byte is meaningful; upper read data is discarded.
    assign unused_mem_bits = ^mem_data_in[31:8];

    exc_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (state == FETCH),
        .load_value (3'(MEM_LATENCY - 1)),
        .dec        (state == WAIT),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            mem_rd_req        <= 1'b0;
            mem_addr          <= 32'd0;
            exception_destiny <= 32'd0;
            epc_out           <= 32'd0;
            pc_load           <= 1'b0;
            busy              <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_any) begin
                        epc_out    <= pc_current - 32'(PC_OFFSET);
                        mem_addr   <= 32'(VEC_BASE) + 32'(cause_to_idx(cause_sel));
                        mem_rd_req <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    mem_rd_req <= 1'b0;
                    state      <= cnt_zero ? LOAD : WAIT;
                end
                WAIT: begin
                    if (cnt_zero)
                        state <= LOAD;
                end
                LOAD: begin
                    // pc_load rises together with the new exception_destiny,
                    // i.e. in the cycle after the byte is captured.
                    exception_destiny <= {24'd0, mem_data_in[7:0]};
                    pc_load           <= 1'b1;
                    busy              <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXC_CAUSE_REG_EN
    always_ff @(posedge clk) begin
        if (!reset)
            cause_out <= CAUSE_NONE;
        else if (state == IDLE && exc_any)
            cause_out <= cause_sel;
    end
`endif

endmodule
